// File: rtl/rr_grant_enc4.sv
// Four-requester round-robin arbiter that drives a 2-to-4 decoder with {sel_b_o, sel_a_o}.
// Optional RR_BACK2BACK_EN: re-grant in the ack cycle without an IDLE bubble.
module rr_grant_enc4 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       ack_i,
    output logic       sel_a_o,
    output logic       sel_b_o,
    output logic       valid_o,
    output logic       timeout_o
);

    localparam int unsigned WdW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        StIdle,
        StGrant
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     idx_q, idx_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
    logic [2:0]     win;

    // Returns {found, index} for the first set bit scanning start, start+1, ... (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] i;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            i = start + 2'(k);
            if (req[i]) begin
                res = {1'b1, i};
            end
        end
        return res;
    endfunction

`ifdef RR_BACK2BACK_EN
    logic [2:0] nxt;
    assign nxt = rr_pick(req_i & ~(4'b0001 << idx_q), idx_q + 2'd1);
`endif

    assign win = rr_pick(req_i, ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win[2]) begin
                    idx_d   = win[1:0];
                    wd_d    = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // ack takes priority over a watchdog expiry in the same cycle
                if (ack_i) begin
                    ptr_d = idx_q + 2'd1;
`ifdef RR_BACK2BACK_EN
                    if (nxt[2]) begin
                        idx_d = nxt[1:0];
                        wd_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else if (TIMEOUT != 0 && wd_q == WdLast) begin
                    ptr_d     = idx_q + 2'd1;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_o   = (state_q == StGrant);
        sel_a_o   = idx_q[0];
        sel_b_o   = idx_q[1];
        timeout_o = timeout_q;
    end

endmodule

// File: tb/tb_rr_grant_enc4.sv
// Randomized and directed bench for rr_grant_enc4 against a rule-level round-robin model.
module tb_rr_grant_enc4;

    localparam int unsigned Tmo = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       sel_a, sel_b, valid, timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_gr;
    int m_idx, m_ptr, m_wd, m_age;
    bit m_to;
    int n_to_seen;
    int n_valid_seen;

    rr_grant_enc4 #(.TIMEOUT(Tmo)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .ack_i    (ack),
        .sel_a_o  (sel_a),
        .sel_b_o  (sel_b),
        .valid_o  (valid),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requesting index in order start, start+1, ... (mod 4), ignoring index skip.
    function automatic int rr_pick(input logic [3:0] r, input int start, input int skip);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic a);
        int w;
        m_to = 1'b0;
        if (r) begin
            m_gr = 0; m_ptr = 0; m_idx = 0; m_wd = 0; m_age = 0;
        end else if (!m_gr) begin
            w = rr_pick(rq, m_ptr, -1);
            if (w >= 0) begin
                m_gr = 1; m_idx = w; m_wd = 0; m_age = 0;
            end
        end else if (a) begin
            m_ptr = (m_idx + 1) % 4;
`ifdef RR_BACK2BACK_EN
            w = rr_pick(rq, (m_idx + 1) % 4, m_idx);
            if (w >= 0) begin
                m_idx = w; m_wd = 0; m_age = 0;
            end else begin
                m_gr = 0;
            end
`else
            m_gr = 0;
`endif
        end else if (Tmo > 0 && m_wd == Tmo - 1) begin
            m_ptr = (m_idx + 1) % 4;
            m_gr  = 0;
            m_to  = 1'b1;
        end else begin
            m_wd++;
            m_age++;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic a);
        rst = r;
        req = rq;
        ack = a;
        @(posedge clk);
        model_edge(r, rq, a);
        #1;
        check_eq("valid", {7'd0, valid}, {7'd0, m_gr});
        check_eq("sel", {6'd0, sel_b, sel_a}, 8'(m_idx));
        check_eq("timeout", {7'd0, timeout}, {7'd0, m_to});
        if (timeout) n_to_seen++;
        if (valid) n_valid_seen++;
    endtask

    initial begin
        m_gr = 0; m_idx = 0; m_ptr = 0; m_wd = 0; m_age = 0; m_to = 0;
        rst = 1'b1; req = 4'b0000; ack = 1'b0;
        #2;
        step(1'b1, 4'b1111, 1'b1);
        check_eq("rst_valid", {7'd0, valid}, 8'd0);

        // Idle with no requests
        repeat (5) step(1'b0, 4'b0000, 1'b0);

        // 1010, ack in the second cycle of each grant
        repeat (14) step(1'b0, 4'b1010, m_gr && m_age == 1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // 1111, ack every valid cycle: pointer wraps 3 -> 0
        repeat (12) step(1'b0, 4'b1111, m_gr);
        repeat (2) step(1'b0, 4'b0000, 1'b1);

        // Watchdog: single requester, never acked
        n_to_seen    = 0;
        n_valid_seen = 0;
        repeat (5) step(1'b0, 4'b0100, 1'b0);
        check_eq("wd_valid_cycles", 8'(n_valid_seen), 8'(Tmo));
        step(1'b0, 4'b0000, 1'b0);
        check_eq("wd_pulses", 8'(n_to_seen), 8'd1);
        check_eq("wd_idle", {7'd0, valid}, 8'd0);
        step(1'b0, 4'b0100, 1'b0);
        check_eq("wd_regrant_idx", {6'd0, sel_b, sel_a}, 8'd2);

        // Granted line drops, another rises: idx frozen until ack
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        check_eq("frozen_idx", {6'd0, sel_b, sel_a}, 8'd2);
        step(1'b0, 4'b0001, 1'b1);
        repeat (2) step(1'b0, 4'b0001, 1'b0);
        check_eq("next_idx0", {6'd0, sel_b, sel_a}, 8'd0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Reset mid-grant at idx 3
        repeat (2) step(1'b0, 4'b1000, 1'b0);
        check_eq("pre_rst_idx", {6'd0, sel_b, sel_a}, 8'd3);
        step(1'b1, 4'b1000, 1'b0);
        check_eq("rst_mid_valid", {7'd0, valid}, 8'd0);
        step(1'b0, 4'b1001, 1'b0);
        check_eq("post_rst_idx", {6'd0, sel_b, sel_a}, 8'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 80) == 0, 4'($urandom), ($urandom % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
